config_sram_burst_loader: RTL
=============================

// Module: config_sram_burst_loader
// PURPOSE
//  Serial-to-parallel configuration loader for multi-bank config SRAMs.
//  Deserialises a framed bitstream (header + burst of data words) from the config shift chain.
//  Issues one-cycle write strobes to one of NUM_BANKS SRAM banks with an auto-incrementing
//  address, so a bank is loaded in one frame instead of one set pulse per word.
// PARAMETERS
//  ADDR_BITS  8  SRAM word-address width per bank
//  DATA_BITS  8  SRAM word width
//  NUM_BANKS  4  number of banks (>=1); BANK_BITS = max(1,clog2(NUM_BANKS)) is a localparam
// PORTS
//  cclk           in   1            config clock; all logic on rising edge
//  rst            in   1            synchronous, active-high reset
//  shift_enable   in   1            shift_in is consumed only in cycles where this is 1
//  shift_in       in   1            serial frame bit, MSB-first per field
//  shift_out      out  1            shift_in registered on each enabled cycle (daisy chain); holds otherwise
//  config_set     in   1            synchronous resync/abort: return to IDLE, clear error
//  write_address  out  ADDR_BITS    registered write address
//  write_data     out  DATA_BITS    registered write data
//  write_enable   out  NUM_BANKS    one-hot registered write strobe, one cycle per word
//  busy           out  1            1 while state != IDLE
//  done           out  1            one-cycle pulse at end of frame
//  error          out  1            sticky: frame addressed bank >= NUM_BANKS
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; counters 0. rst overrides every other input.
//  - Frame: header = {bank[BANK_BITS], base[ADDR_BITS], cnt_m1[ADDR_BITS]}, then cnt_m1+1 data
//    words of DATA_BITS each. cnt_m1 all-ones = 2^ADDR_BITS words.
//  - FSM: IDLE -(enabled bit)-> HEADER -(last header bit)-> DATA -(last bit of last word)-> IDLE.
//    The first enabled bit in IDLE is header bit 0. Cycles without shift_enable do not advance the FSM.
//  - Write: on the edge after the edge capturing a word's last bit, write_enable[bank]=1 for exactly
//    one cycle, write_address=base+k (k = word index, mod 2^ADDR_BITS wrap), write_data=word.
//    Addr/data hold their last value when no strobe is active.
//  - No stall: a strobe coincides with the next word's first bit; back-to-back words write every
//    DATA_BITS enabled cycles.
//  - done pulses in the same cycle as the final write_enable. busy drops in that cycle.
//  - Bad bank (bank >= NUM_BANKS): error<=1 when header completes; data words are consumed;
//    write_enable stays 0; done still pulses. error persists across frames until rst or config_set.
//  - config_set (priority over shift_enable): state->IDLE, bit/word counters cleared, error<=0.
//    The bit presented in that cycle is discarded. A strobe already on the outputs this cycle is not
//    retracted; no further strobes from the aborted frame.
//  - shift_out updates with shift_in whenever shift_enable=1, regardless of state or config_set.
// STRUCTURE
//  - Shared include config_defs.vh: header field order/offsets, state encodings, the clog2 function.
//  - Sub-module config_deserializer: bit counter + shift register. Pulses word_valid with a
//    WIDTH-bit word; width is selected per field (header vs data).
//  - Top: FSM, base/count/word-index registers, address adder, one-hot bank decode, output registers.
// TESTING (ADDR=8, DATA=8, NUM_BANKS=4 unless stated)
//  1. bank=1, base=0x10, cnt_m1=2, data A5,3C,FF, shift_enable held 1 ->
//     write_enable=4'b0010 at 10/A5, 11/3C, 12/FF, 8 cycles apart; done with 3rd; busy 0 after.
//  2. bank=0, base=0xFE, cnt_m1=3 -> writes at FE, FF, 00, 01 (wrap); no other bank strobed.
//  3. Case 1 with shift_enable toggling every cycle -> identical writes, 16 cycles apart;
//     shift_out echoes shift_in delayed by one enabled cycle.
//  4. NUM_BANKS=3, bank=3, cnt_m1=1 -> error=1, zero strobes, done pulses. Next valid frame writes
//     normally with error still 1; config_set clears it.
//  5. Case 1 with config_set after word 1 -> single write 10/A5, busy 0, no done. A following
//     bank=2 frame loads correctly.
//  6. rst asserted mid-header -> all outputs 0 next cycle; a fresh frame then loads correctly.

Source files
------------

// File: rtl/config_sram_burst_loader_pkg.sv
// Shared definitions for the config SRAM burst loader.
// Holds the FSM state encoding, the header field layout and a clog2 helper.
// Header word as assembled by the deserializer (MSB = first bit shifted in):
//   {bank[BANK_BITS], base[ADDR_BITS], cnt_m1[ADDR_BITS]}
package config_sram_burst_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } state_e;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int bank_bits_f(input int nb);
    return (nb <= 1) ? 1 : clog2_f(nb);
  endfunction

  // Field LSB offsets inside the assembled header word.
  function automatic int cnt_lsb_f(input int ab);
    return 0 * ab;
  endfunction

  function automatic int base_lsb_f(input int ab);
    return ab;
  endfunction

  function automatic int bank_lsb_f(input int ab);
    return 2 * ab;
  endfunction

  function automatic int hdr_bits_f(input int bb, input int ab);
    return bb + 2 * ab;
  endfunction

endpackage

// File: rtl/config_sram_burst_loader_deser.sv
// Bit counter + shift register for the config frame.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   clr_i             resync: drop the partial word and any pending word_valid
//   en_i              consume bit_i this cycle
//   hdr_sel_i         1: current field is the header (HDR_W bits), 0: data word (DATA_W bits)
//   bit_i             serial bit, MSB first
//   last_bit_o        combinational: this enabled bit completes the current field
//   word_valid_o      registered one-cycle pulse after the last bit was captured
//   word_is_hdr_o     field type of the word presented with word_valid_o
//   word_o            shift register contents; the field sits in the low bits
module config_sram_burst_loader_deser
  import config_sram_burst_loader_pkg::*;
#(
  parameter int HDR_W  = 18,
  parameter int DATA_W = 8,
  localparam int SR_W  = (HDR_W > DATA_W) ? HDR_W : DATA_W
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic            hdr_sel_i,
  input  logic            bit_i,
  output logic            last_bit_o,
  output logic            word_valid_o,
  output logic            word_is_hdr_o,
  output logic [SR_W-1:0] word_o
);

  localparam int CW = (clog2_f(SR_W) < 1) ? 1 : clog2_f(SR_W);

  logic [CW-1:0]   cnt_q;
  logic [SR_W-1:0] sr_q;
  logic            valid_q;
  logic            is_hdr_q;
  logic [CW-1:0]   top_idx;

  assign top_idx    = hdr_sel_i ? CW'(HDR_W - 1) : CW'(DATA_W - 1);
  assign last_bit_o = en_i & (cnt_q == top_idx);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q    <= '0;
      sr_q     <= '0;
      valid_q  <= 1'b0;
      is_hdr_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (en_i) begin
        sr_q <= {sr_q[SR_W-2:0], bit_i};
        if (last_bit_o) begin
          cnt_q    <= '0;
          valid_q  <= 1'b1;
          is_hdr_q <= hdr_sel_i;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign word_valid_o  = valid_q;
  assign word_is_hdr_o = is_hdr_q;
  assign word_o        = sr_q;

endmodule

// File: rtl/config_sram_burst_loader.sv
// Serial-to-parallel loader for multi-bank configuration SRAMs.
// A frame is a header {bank, base, cnt_m1} followed by cnt_m1+1 data words;
// each word becomes one write strobe at base+k on the addressed bank.
// Ports:
//   cclk, rst            config clock, synchronous active-high reset
//   shift_enable         qualifies shift_in
//   shift_in / shift_out serial input and its one-enabled-cycle-delayed echo
//   config_set           abort/resync: back to IDLE, clears error
//   write_address/data   registered SRAM write port, hold between strobes
//   write_enable         one-hot per bank, one cycle per word
//   busy, done, error    status (done pulses with the final strobe, error sticky)
module config_sram_burst_loader
  import config_sram_burst_loader_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int NUM_BANKS = 4
) (
  input  logic                 cclk,
  input  logic                 rst,
  input  logic                 shift_enable,
  input  logic                 shift_in,
  output logic                 shift_out,
  input  logic                 config_set,
  output logic [ADDR_BITS-1:0] write_address,
  output logic [DATA_BITS-1:0] write_data,
  output logic [NUM_BANKS-1:0] write_enable,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int BANK_BITS = bank_bits_f(NUM_BANKS);
  localparam int HDR_BITS  = hdr_bits_f(BANK_BITS, ADDR_BITS);
  localparam int SR_W      = (HDR_BITS > DATA_BITS) ? HDR_BITS : DATA_BITS;
  localparam int BANK_LSB  = bank_lsb_f(ADDR_BITS);
  localparam int BASE_LSB  = base_lsb_f(ADDR_BITS);
  localparam int CNT_LSB   = cnt_lsb_f(ADDR_BITS);
  localparam logic [BANK_BITS:0] NB = (BANK_BITS + 1)'(NUM_BANKS);

  state_e               state_q;
  logic [BANK_BITS-1:0] bank_q;
  logic [ADDR_BITS-1:0] base_q, cnt_q, dcnt_q, k_q;
  logic                 bad_q, last_pend_q;
  logic [NUM_BANKS-1:0] we_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 done_q, busy_q, err_q, so_q;

  // config_set steals the cycle: its bit never reaches the deserializer.
  logic            en;
  logic            last_bit, word_valid, word_is_hdr;
  logic [SR_W-1:0] word;

  assign en = shift_enable & ~config_set;

  config_sram_burst_loader_deser #(
    .HDR_W  (HDR_BITS),
    .DATA_W (DATA_BITS)
  ) u_deser (
    .clk_i         (cclk),
    .rst_i         (rst),
    .clr_i         (config_set),
    .en_i          (en),
    .hdr_sel_i     (state_q != ST_DATA),
    .bit_i         (shift_in),
    .last_bit_o    (last_bit),
    .word_valid_o  (word_valid),
    .word_is_hdr_o (word_is_hdr),
    .word_o        (word)
  );

  logic [BANK_BITS-1:0] hdr_bank;
  logic [ADDR_BITS-1:0] hdr_base, hdr_cnt, cnt_eff;
  logic                 hdr_bad, hdr_now, final_wr;
  logic [NUM_BANKS-1:0] bank_oh;

  assign hdr_bank = word[BANK_LSB +: BANK_BITS];
  assign hdr_base = word[BASE_LSB +: ADDR_BITS];
  assign hdr_cnt  = word[CNT_LSB  +: ADDR_BITS];
  assign hdr_bad  = {1'b0, hdr_bank} >= NB;
  assign hdr_now  = word_valid & word_is_hdr;
  assign final_wr = word_valid & ~word_is_hdr & last_pend_q;
  // The header registers land one edge after the header's last bit; with very
  // short data words the first data word can finish on that same edge.
  assign cnt_eff  = hdr_now ? hdr_cnt : cnt_q;

  always_comb begin
    bank_oh = '0;
    for (int i = 0; i < NUM_BANKS; i++)
      if (bank_q == BANK_BITS'(i)) bank_oh[i] = 1'b1;
  end

  always_ff @(posedge cclk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bank_q      <= '0;
      base_q      <= '0;
      cnt_q       <= '0;
      dcnt_q      <= '0;
      k_q         <= '0;
      bad_q       <= 1'b0;
      last_pend_q <= 1'b0;
      we_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      so_q        <= 1'b0;
    end else begin
      if (shift_enable) so_q <= shift_in;
      we_q   <= '0;
      done_q <= 1'b0;
      if (config_set) begin
        state_q     <= ST_IDLE;
        dcnt_q      <= '0;
        k_q         <= '0;
        last_pend_q <= 1'b0;
        busy_q      <= 1'b0;
        err_q       <= 1'b0;
      end else begin
        // Word-level side: one edge behind the bit that completed the word.
        if (word_valid) begin
          if (word_is_hdr) begin
            bank_q <= hdr_bank;
            base_q <= hdr_base;
            cnt_q  <= hdr_cnt;
            k_q    <= '0;
            bad_q  <= hdr_bad;
            if (hdr_bad) err_q <= 1'b1;
          end else begin
            if (!bad_q) begin
              we_q   <= bank_oh;
              addr_q <= base_q + k_q;
              data_q <= word[DATA_BITS-1:0];
            end
            k_q <= k_q + 1'b1;
            if (last_pend_q) begin
              done_q      <= 1'b1;
              last_pend_q <= 1'b0;
            end
          end
        end
        if (final_wr) busy_q <= 1'b0;

        // Bit-level FSM; a new frame may start on the final strobe's edge.
        case (state_q)
          ST_IDLE: if (en) begin
            state_q <= ST_HEADER;
            busy_q  <= 1'b1;
          end
          ST_HEADER: if (last_bit) begin
            state_q <= ST_DATA;
            dcnt_q  <= '0;
          end
          ST_DATA: if (last_bit) begin
            if (dcnt_q == cnt_eff) begin
              state_q     <= ST_IDLE;
              last_pend_q <= 1'b1;
            end else begin
              dcnt_q <= dcnt_q + 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign write_enable  = we_q;
  assign write_address = addr_q;
  assign write_data    = data_q;
  assign done          = done_q;
  assign busy          = busy_q;
  assign error         = err_q;
  assign shift_out     = so_q;

endmodule
